// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, ExcCodes, Status/Cause bit positions and reset constants.
package cp0_pkg;
    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_RANDOM   = 5'd1;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_CONTEXT  = 5'd4;
    localparam logic [4:0] CP0_PAGEMASK = 5'd5;
    localparam logic [4:0] CP0_WIRED    = 5'd6;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_EBASE    = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13
    } exc_code_e;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int CA_BD  = 31;
    localparam int CA_IV  = 23;
    localparam int CA_WP  = 22;

    localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: prescaled Count, Compare and the sticky Count==Compare timer interrupt.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] data_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(COUNT_DIV - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre         <= '0;
            count_o     <= '0;
            compare_o   <= '0;
            timer_int_o <= 1'b0;
        end else begin
            if (count_we) begin
                count_o <= data_i;
                pre     <= '0;
            end else if (pre == PRE_TOP) begin
                count_o <= count_o + 32'd1;
                pre     <= '0;
            end else begin
                pre <= pre + PW'(1);
            end
            // a Compare write acknowledges the interrupt even if a match lands that cycle
            if (compare_we) begin
                compare_o   <= data_i;
                timer_int_o <= 1'b0;
            end else if (count_o == compare_o && compare_o != '0) begin
                timer_int_o <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/cp0_ctrl_unit.sv
// cp0_ctrl_unit: CP0 register file, exception/ERET commit, interrupt request and vector.
// Optional TLB registers (Index/EntryLo0/1/Context/PageMask/EntryHi) enabled by CP0_TLB_REGS_EN.
import cp0_pkg::*;

module cp0_ctrl_unit #(
    parameter int          NUM_HW_INT  = 6,
    parameter int          TLB_ENTRIES = 16,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] EBASE_RESET = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           data_i,
    input  logic [4:0]            raddr_i,
    output logic [31:0]           data_o,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic                  eret_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_delayslot_i,
    input  logic [31:0]           badvaddr_i,
    input  logic                  tlbwr_i,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           ebase_o,
    output logic                  irq_pending_o,
    output logic [31:0]           exc_vector_o,
    output logic                  timer_int_o
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);
    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    logic [31:0]           count, compare, status, epc, badvaddr, wired;
    logic                  bd, iv, wp;
    logic [1:0]            ip_sw;
    logic [NUM_HW_INT-1:0] ip_hw;
    logic [4:0]            exc_code;
    logic [17:0]           eb;
    logic [IDX_W-1:0]      random;
    logic [5:0]            hw6;
    logic [7:0]            ip;
    logic                  w_status, w_cause, w_epc, w_ebase, w_wired;
    logic                  unused_tlbwr;

    assign unused_tlbwr = tlbwr_i;
    assign w_status = we_i && waddr_i == CP0_STATUS;
    assign w_cause  = we_i && waddr_i == CP0_CAUSE;
    assign w_epc    = we_i && waddr_i == CP0_EPC;
    assign w_ebase  = we_i && waddr_i == CP0_EBASE;
    assign w_wired  = we_i && waddr_i == CP0_WIRED;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (we_i && waddr_i == CP0_COUNT),
        .compare_we (we_i && waddr_i == CP0_COMPARE),
        .data_i     (data_i),
        .count_o    (count),
        .compare_o  (compare),
        .timer_int_o(timer_int_o)
    );

    // IP7 is shared by the timer and the top hardware line when six lines are present
    assign hw6           = 6'(ip_hw);
    assign ip            = {hw6[5] | timer_int_o, hw6[4:0], ip_sw};
    assign status_o      = status;
    assign cause_o       = {bd, 7'b0, iv, wp, 6'b0, ip, 1'b0, exc_code, 2'b0};
    assign epc_o         = epc;
    assign ebase_o       = {2'b10, eb, 12'h000};
    assign exc_vector_o  = {ebase_o[31:12], 12'h180};
    assign irq_pending_o = status[ST_IE] & ~status[ST_EXL] & |(ip & status[15:8]);

`ifdef CP0_TLB_REGS_EN
    logic [IDX_W-1:0] index;
    logic [29:0]      entrylo0, entrylo1;
    logic [31:0]      context_r, entryhi;
    logic [15:0]      pagemask;

    always_ff @(posedge clk) begin
        if (rst) begin
            index     <= '0;
            entrylo0  <= '0;
            entrylo1  <= '0;
            context_r <= '0;
            pagemask  <= '0;
            entryhi   <= '0;
        end else if (we_i) begin
            if (waddr_i == CP0_INDEX) index <= data_i[IDX_W-1:0];
            if (waddr_i == CP0_ENTRYLO0) entrylo0 <= data_i[29:0];
            if (waddr_i == CP0_ENTRYLO1) entrylo1 <= data_i[29:0];
            if (waddr_i == CP0_CONTEXT) context_r <= data_i;
            if (waddr_i == CP0_PAGEMASK) pagemask <= data_i[28:13];
            if (waddr_i == CP0_ENTRYHI) entryhi <= data_i;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            status   <= STATUS_RESET;
            bd       <= 1'b0;
            iv       <= 1'b0;
            wp       <= 1'b0;
            ip_sw    <= '0;
            ip_hw    <= '0;
            exc_code <= '0;
            epc      <= '0;
            badvaddr <= '0;
            eb       <= EBASE_RESET[29:12];
            wired    <= '0;
            random   <= RAND_TOP;
        end else begin
            ip_hw <= int_i;
            if (w_status) status <= data_i;
            if (w_cause) {iv, wp, ip_sw} <= {data_i[CA_IV], data_i[CA_WP], data_i[9:8]};
            if (w_epc) epc <= data_i;
            if (w_ebase) eb <= data_i[29:12];
            if (w_wired) wired <= data_i;
            random <= (w_wired || wired >= 32'(TLB_ENTRIES) || random == wired[IDX_W-1:0])
                      ? RAND_TOP : random - IDX_W'(1);
            // exception and ERET commit override MTC0 on the fields they own
            if (exc_valid_i) begin
                status[ST_EXL] <= 1'b1;
                exc_code       <= exc_code_i;
                if (!status[ST_EXL]) begin
                    epc <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
                    bd  <= in_delayslot_i;
                end
                if (exc_code_i == EXC_ADEL || exc_code_i == EXC_ADES) badvaddr <= badvaddr_i;
            end else if (eret_i) begin
                status[ST_EXL] <= 1'b0;
            end
        end
    end

    always_comb begin
        data_o = '0;
        if (!rst) begin
            case (raddr_i)
                CP0_RANDOM:   data_o = 32'(random);
                CP0_WIRED:    data_o = wired;
                CP0_BADVADDR: data_o = badvaddr;
                CP0_COUNT:    data_o = count;
                CP0_COMPARE:  data_o = compare;
                CP0_STATUS:   data_o = status_o;
                CP0_CAUSE:    data_o = cause_o;
                CP0_EPC:      data_o = epc_o;
                CP0_EBASE:    data_o = ebase_o;
`ifdef CP0_TLB_REGS_EN
                CP0_INDEX:    data_o = 32'(index);
                CP0_ENTRYLO0: data_o = {2'b00, entrylo0};
                CP0_ENTRYLO1: data_o = {2'b00, entrylo1};
                CP0_CONTEXT:  data_o = context_r;
                CP0_PAGEMASK: data_o = {3'b000, pagemask, 13'h0};
                CP0_ENTRYHI:  data_o = entryhi;
`endif
                default:      data_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_cp0_ctrl_unit.sv
// tb_cp0_ctrl_unit: directed checks of the CP0 unit in its default build.
`timescale 1ns/100ps
module tb_cp0_ctrl_unit;
    import cp0_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, we = 1'b0, exc_valid = 1'b0, eret = 1'b0;
    logic        ds = 1'b0, tlbwr = 1'b0;
    logic [4:0]  waddr = '0, raddr = '0, exc_code = '0;
    logic [5:0]  int_i = '0;
    logic [31:0] wdata = '0, pc = '0, bva = '0, data_o;
    logic [31:0] status_o, cause_o, epc_o, ebase_o, exc_vector_o, v;
    logic        irq_pending_o, timer_int_o, found;
    int          n_tests = 0, n_fail = 0;

    cp0_ctrl_unit dut (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .data_i(wdata), .raddr_i(raddr),
        .data_o(data_o), .int_i(int_i), .exc_valid_i(exc_valid), .exc_code_i(exc_code),
        .eret_i(eret), .pc_i(pc), .in_delayslot_i(ds), .badvaddr_i(bva), .tlbwr_i(tlbwr),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .ebase_o(ebase_o),
        .irq_pending_o(irq_pending_o), .exc_vector_o(exc_vector_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] val);
        raddr = a;
        #0.1;
        val = data_o;
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] r;
        rd(a, r);
        chk(tag, r, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] p, input logic slot,
                       input logic [31:0] addr, input logic with_eret);
        exc_valid = 1'b1;
        exc_code = code;
        pc = p;
        ds = slot;
        bva = addr;
        eret = with_eret;
        step();
        exc_valid = 1'b0;
        eret = 1'b0;
        ds = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk_rd("data_in_reset", CP0_STATUS, 32'h0);
        rst = 1'b0;
        chk_rd("rst_status", CP0_STATUS, 32'h1000_0000);
        chk_rd("rst_cause", CP0_CAUSE, 32'h0);
        chk_rd("rst_epc", CP0_EPC, 32'h0);
        chk_rd("rst_ebase", CP0_EBASE, 32'h8000_0000);
        chk_rd("rst_random", CP0_RANDOM, 32'd15);
        chk_rd("rst_count", CP0_COUNT, 32'd0);
        chk("rst_timer", 32'(timer_int_o), 32'd0);

        // timer: Compare=5, poll until Count reaches it
        mtc0(CP0_COMPARE, 32'd5);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            rd(CP0_COUNT, v);
            if (v == 32'd5) found = 1'b1;
            else step();
        end
        chk("count_reach_5", 32'(found), 32'd1);
        chk("timer_not_yet", 32'(timer_int_o), 32'd0);
        step();
        chk("timer_set", 32'(timer_int_o), 32'd1);
        chk("cause_ip7", 32'(cause_o[15]), 32'd1);
        step();
        chk("timer_sticky", 32'(timer_int_o), 32'd1);
        mtc0(CP0_COMPARE, 32'd0);
        chk("timer_cleared", 32'(timer_int_o), 32'd0);
        chk("cause_ip7_clr", 32'(cause_o[15]), 32'd0);

        // Count load and prescale by 2
        mtc0(CP0_COUNT, 32'd100);
        chk_rd("count_load", CP0_COUNT, 32'd100);
        step();
        chk_rd("count_div_hold", CP0_COUNT, 32'd100);
        step();
        chk_rd("count_div_inc", CP0_COUNT, 32'd101);

        // interrupt request and exception entry/exit
        int_i = 6'b000001;
        mtc0(CP0_STATUS, 32'h0000_FF01);
        chk("irq_pending", 32'(irq_pending_o), 32'd1);
        chk("cause_ip2", 32'(cause_o[10]), 32'd1);
        exc(5'd0, 32'h8000_0200, 1'b0, 32'h0, 1'b0);
        chk("exc_exl", 32'(status_o[1]), 32'd1);
        chk("irq_masked_exl", 32'(irq_pending_o), 32'd0);
        chk("exc_epc", epc_o, 32'h8000_0200);
        chk("exc_vector", exc_vector_o, 32'h8000_0180);
        exc(5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("eret_exl", 32'(status_o[1]), 32'd0);
        chk("irq_after_eret", 32'(irq_pending_o), 32'd1);
        int_i = 6'b0;
        step();
        chk("irq_drop", 32'(irq_pending_o), 32'd0);

        // delay-slot EPC and nested exception
        exc(5'd12, 32'h8000_0104, 1'b1, 32'h0, 1'b0);
        chk("ds_epc", epc_o, 32'h8000_0100);
        chk("ds_bd", 32'(cause_o[31]), 32'd1);
        chk("ds_code", 32'(cause_o[6:2]), 32'd12);
        exc(5'd8, 32'h0000_1234, 1'b0, 32'h0, 1'b0);
        chk("nest_epc_held", epc_o, 32'h8000_0100);
        chk("nest_bd_held", 32'(cause_o[31]), 32'd1);
        chk("nest_code", 32'(cause_o[6:2]), 32'd8);

        // address error, ERET, exception beating ERET
        exc(5'd5, 32'h0000_2000, 1'b0, 32'h0000_0003, 1'b0);
        chk_rd("badvaddr", CP0_BADVADDR, 32'h0000_0003);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("eret_clear", 32'(status_o[1]), 32'd0);
        exc(5'd9, 32'h0000_3000, 1'b0, 32'h0, 1'b1);
        chk("exc_beats_eret", 32'(status_o[1]), 32'd1);
        eret = 1'b1;
        step();
        eret = 1'b0;

        // Random / Wired
        mtc0(CP0_WIRED, 32'd4);
        chk_rd("random_top", CP0_RANDOM, 32'd15);
        for (int i = 0; i < 11; i++) step();
        chk_rd("random_at_wired", CP0_RANDOM, 32'd4);
        step();
        chk_rd("random_wrap", CP0_RANDOM, 32'd15);
        mtc0(CP0_RANDOM, 32'd7);
        chk_rd("random_ro", CP0_RANDOM, 32'd14);
        mtc0(CP0_WIRED, 32'd20);
        step();
        step();
        chk_rd("random_big_wired", CP0_RANDOM, 32'd15);
        mtc0(CP0_WIRED, 32'd0);

        // absent TLB registers, EBase masking, unimplemented register
        mtc0(CP0_ENTRYHI, 32'hFFFF_FFFF);
        chk_rd("entryhi_absent", CP0_ENTRYHI, 32'h0);
        mtc0(CP0_EBASE, 32'hFFFF_F000);
        chk_rd("ebase_mask", CP0_EBASE, 32'hBFFF_F000);
        chk("ebase_vector", exc_vector_o, 32'hBFFF_F180);
        mtc0(5'd7, 32'hDEAD_BEEF);
        chk_rd("unimpl_reg", 5'd7, 32'h0);

        // reset during exception, then Cause write mask
        exc(5'd13, 32'h0000_4000, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_drops_exc", status_o, 32'h1000_0000);
        mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
        chk_rd("cause_wmask", CP0_CAUSE, 32'h00C0_0300);
        mtc0(CP0_EPC, 32'h1234_5678);
        chk_rd("epc_write", CP0_EPC, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
